csrng_upd_arb: RTL

- Shares one ctr_drbg update unit between NumReq requesters, e.g. the cmd stage (index 0) and the generate stage (index 1).
- Forwards the granted request to the update unit with zero added latency.
- Records which requester owns each accepted request in an in-order tag FIFO, and steers each update-unit response back to that owner.
- Sits in csrng_core between the ctr_drbg cmd/gen stages and the update unit.

---
 rtl/csrng_upd_arb.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/csrng_upd_arb.sv
// csrng_upd_arb: shares one ctr_drbg update unit between NumReq requesters.
//
// Request path: a round-robin arbiter picks one eligible requester and forwards its
// payload to the update unit combinationally. A grant that is offered but not yet
// accepted is locked so the payload seen by the update unit stays stable.
// Response path: every accepted request pushes its owner index into an in-order tag
// FIFO. The head tag steers each update-unit response back to its owner.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   enable_i               module enable; low clears all state and zeroes all outputs
//   req_i / rdy_o          per-requester request valid / request accepted
//   req_*_i                packed per-requester payload (ccmd, inst_id, pdata, key, v)
//   upd_req_o / upd_rdy_i  request handshake towards the update unit
//   upd_*_o                payload of the granted requester
//   upd_ack_i / upd_rdy_o  response handshake from the update unit
//   upd_*_i                response payload from the update unit
//   ack_o / rsp_rdy_i      per-requester response valid / response ready
//   rsp_*_o                broadcast response payload, valid only with ack_o
//   outstanding_o          tag FIFO occupancy
//   err_o                  {rsp_with_no_tag, push_while_full, pop_while_empty} pulses
module csrng_upd_arb #(
    parameter int unsigned NumReq   = 2,
    parameter int unsigned TagDepth = 2,
    parameter int unsigned Cmd      = 3,
    parameter int unsigned StateId  = 4,
    parameter int unsigned BlkLen   = 128,
    parameter int unsigned KeyLen   = 256,
    parameter int unsigned SeedLen  = 384,
    localparam int unsigned TagW    = (NumReq > 1) ? $clog2(NumReq) : 1,
    localparam int unsigned PtrW    = (TagDepth > 1) ? $clog2(TagDepth) : 1,
    localparam int unsigned CntW    = $clog2(TagDepth + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        enable_i,
    // requester side
    input  logic [NumReq-1:0]           req_i,
    output logic [NumReq-1:0]           rdy_o,
    input  logic [NumReq*Cmd-1:0]       req_ccmd_i,
    input  logic [NumReq*StateId-1:0]   req_inst_id_i,
    input  logic [NumReq*SeedLen-1:0]   req_pdata_i,
    input  logic [NumReq*KeyLen-1:0]    req_key_i,
    input  logic [NumReq*BlkLen-1:0]    req_v_i,
    // update unit request side
    output logic                        upd_req_o,
    input  logic                        upd_rdy_i,
    output logic [Cmd-1:0]              upd_ccmd_o,
    output logic [StateId-1:0]          upd_inst_id_o,
    output logic [SeedLen-1:0]          upd_pdata_o,
    output logic [KeyLen-1:0]           upd_key_o,
    output logic [BlkLen-1:0]           upd_v_o,
    // update unit response side
    input  logic                        upd_ack_i,
    output logic                        upd_rdy_o,
    input  logic [Cmd-1:0]              upd_ccmd_i,
    input  logic [StateId-1:0]          upd_inst_id_i,
    input  logic [KeyLen-1:0]           upd_key_i,
    input  logic [BlkLen-1:0]           upd_v_i,
    // requester response side
    output logic [NumReq-1:0]           ack_o,
    input  logic [NumReq-1:0]           rsp_rdy_i,
    output logic [Cmd-1:0]              rsp_ccmd_o,
    output logic [StateId-1:0]          rsp_inst_id_o,
    output logic [KeyLen-1:0]           rsp_key_o,
    output logic [BlkLen-1:0]           rsp_v_o,
    // status
    output logic [CntW-1:0]             outstanding_o,
    output logic [2:0]                  err_o
);

    // ------------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------------
    logic [TagW-1:0] r_tag_mem [TagDepth];
    logic [PtrW-1:0] r_wptr;
    logic [PtrW-1:0] r_rptr;
    logic [CntW-1:0] r_count;
    logic [TagW-1:0] r_prio;
    logic            r_lock;
    logic [TagW-1:0] r_lock_idx;

    logic [PtrW-1:0] w_wptr_nxt;
    logic [PtrW-1:0] w_rptr_nxt;
    logic [CntW-1:0] w_count_nxt;
    logic [TagW-1:0] w_prio_nxt;
    logic            w_lock_nxt;
    logic [TagW-1:0] w_lock_idx_nxt;

    logic              w_full;
    logic              w_empty;
    logic [TagW-1:0]   w_head;
    logic [NumReq-1:0] w_elig;
    logic              w_found;
    logic [TagW-1:0]   w_winner;
    logic              w_push;
    logic              w_pop;
    logic              w_rsp_ok;

    assign w_full  = (r_count == CntW'(TagDepth));
    assign w_empty = (r_count == '0);
    assign w_head  = r_tag_mem[r_rptr];

    // ------------------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------------------
    // A full tag FIFO blocks every requester, including a locked one.
    assign w_elig = req_i & {NumReq{enable_i & ~w_full}};

    always_comb begin
        int unsigned idx;
        idx      = 0;
        w_found  = 1'b0;
        w_winner = '0;
        // A lock only holds while its owner keeps requesting; if the owner drops
        // req_i the lock is ignored and the normal search runs this same cycle.
        if (r_lock && w_elig[r_lock_idx]) begin
            w_found  = 1'b1;
            w_winner = r_lock_idx;
        end else begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                idx = int'(r_prio) + i;
                if (idx >= NumReq) begin
                    idx = idx - NumReq;
                end
                if (!w_found && w_elig[idx]) begin
                    w_found  = 1'b1;
                    w_winner = TagW'(idx);
                end
            end
        end
    end

    // Payload mux; zero when nothing is granted.
    always_comb begin
        upd_ccmd_o    = '0;
        upd_inst_id_o = '0;
        upd_pdata_o   = '0;
        upd_key_o     = '0;
        upd_v_o       = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (w_found && (w_winner == TagW'(k))) begin
                upd_ccmd_o    = req_ccmd_i[k*Cmd +: Cmd];
                upd_inst_id_o = req_inst_id_i[k*StateId +: StateId];
                upd_pdata_o   = req_pdata_i[k*SeedLen +: SeedLen];
                upd_key_o     = req_key_i[k*KeyLen +: KeyLen];
                upd_v_o       = req_v_i[k*BlkLen +: BlkLen];
            end
        end
    end

    assign upd_req_o = w_found;
    assign w_push    = w_found & upd_rdy_i;

    always_comb begin
        rdy_o = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (w_push && (w_winner == TagW'(k))) begin
                rdy_o[k] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------------
    // Response routing
    // ------------------------------------------------------------------------------
    assign w_rsp_ok  = enable_i & ~w_empty & rsp_rdy_i[w_head];
    assign upd_rdy_o = w_rsp_ok;
    assign w_pop     = upd_ack_i & w_rsp_ok;

    always_comb begin
        ack_o = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            if (w_pop && (w_head == TagW'(k))) begin
                ack_o[k] = 1'b1;
            end
        end
    end

    assign rsp_ccmd_o    = upd_ccmd_i & {Cmd{enable_i}};
    assign rsp_inst_id_o = upd_inst_id_i & {StateId{enable_i}};
    assign rsp_key_o     = upd_key_i & {KeyLen{enable_i}};
    assign rsp_v_o       = upd_v_i & {BlkLen{enable_i}};

    assign outstanding_o = enable_i ? r_count : '0;

    // Push is already gated by ~full and pop by ~empty; the two low bits only fire
    // if the occupancy state is corrupted.
    assign err_o = {enable_i & upd_ack_i & w_empty, w_push & w_full, w_pop & w_empty};

    // ------------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------------
    always_comb begin
        w_wptr_nxt     = r_wptr;
        w_rptr_nxt     = r_rptr;
        w_count_nxt    = r_count;
        w_prio_nxt     = r_prio;
        w_lock_nxt     = 1'b0;
        w_lock_idx_nxt = r_lock_idx;
        if (w_push) begin
            w_wptr_nxt = (r_wptr == PtrW'(TagDepth - 1)) ? '0 : r_wptr + 1'b1;
            w_prio_nxt = (w_winner == TagW'(NumReq - 1)) ? '0 : w_winner + 1'b1;
        end
        if (w_pop) begin
            w_rptr_nxt = (r_rptr == PtrW'(TagDepth - 1)) ? '0 : r_rptr + 1'b1;
        end
        unique case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
        // Offered but not taken: pin the grant so the payload stays put.
        if (w_found && !upd_rdy_i) begin
            w_lock_nxt     = 1'b1;
            w_lock_idx_nxt = w_winner;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_prio     <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else if (!enable_i) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_prio     <= '0;
            r_lock     <= 1'b0;
            r_lock_idx <= '0;
        end else begin
            r_wptr     <= w_wptr_nxt;
            r_rptr     <= w_rptr_nxt;
            r_count    <= w_count_nxt;
            r_prio     <= w_prio_nxt;
            r_lock     <= w_lock_nxt;
            r_lock_idx <= w_lock_idx_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < TagDepth; i++) begin
                r_tag_mem[i] <= '0;
            end
        end else if (enable_i && w_push) begin
            r_tag_mem[r_wptr] <= w_winner;
        end
    end

endmodule
